// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM encodings, parameter legality
// checks and the sizing rule for the shared stretch/pulse counter.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD     = 2'd0,
        ST_STRETCH  = 2'd1,
        ST_RUN      = 2'd2,
        ST_SW_PULSE = 2'd3
    } rst_seq_state_e;

    localparam int MIN_SYNC_STAGES    = 2;
    localparam int MIN_STRETCH_CYCLES = 1;
    localparam int MIN_PULSE_CYCLES   = 1;
    localparam int MIN_CNT_W          = 1;

    function automatic bit params_legal(
        input int sync_stages,
        input int stretch_cycles,
        input int pulse_cycles,
        input int cnt_w
    );
        return (sync_stages >= MIN_SYNC_STAGES) &&
               (stretch_cycles >= MIN_STRETCH_CYCLES) &&
               (pulse_cycles >= MIN_PULSE_CYCLES) &&
               (cnt_w >= MIN_CNT_W);
    endfunction

    // Counter only ever holds values up to (longest phase - 1).
    function automatic int seq_cnt_width(input int stretch_cycles, input int pulse_cycles);
        int longest;
        longest = (stretch_cycles > pulse_cycles) ? stretch_cycles : pulse_cycles;
        return (longest <= 2) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-deassert synchronizer: clears immediately on async_reset
// and walks a 1 through SYNC_STAGES flops after release.
module reset_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic async_reset,
    output logic synced_release
);

    logic [SYNC_STAGES-1:0] r_chain;

    // Deassertion shift chain; first stage may go metastable, later stages absorb it.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_chain <= {SYNC_STAGES{1'b0}};
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign synced_release = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronizes and stretches the raw reset, then issues
// fixed-width software sync_reset pulses and counts the honored requests.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int STRETCH_CYCLES = 8,
    parameter int PULSE_CYCLES   = 4,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic             sw_reset_req,
    output logic             rst_out,
    output logic             sync_reset,
    output logic             ready,
    output logic [CNT_W-1:0] sw_reset_count
);

    localparam int CW = seq_cnt_width(STRETCH_CYCLES, PULSE_CYCLES);

    if (!params_legal(SYNC_STAGES, STRETCH_CYCLES, PULSE_CYCLES, CNT_W)) begin : g_param_check
        $fatal(1, "reset_sequencer: illegal parameter set");
    end

    logic             w_synced_release;
    rst_seq_state_e   r_state;
    rst_seq_state_e   w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_rst_out;
    logic             r_sync_reset;
    logic             r_ready;
    logic             w_rst_out_nxt;
    logic             w_sync_reset_nxt;
    logic             w_ready_nxt;

    reset_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_reset_sync (
        .clk            (clk),
        .async_reset    (async_reset),
        .synced_release (w_synced_release)
    );

    // Next-state, phase counter and request counter.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_count_nxt = r_count;
        case (r_state)
            ST_HOLD: begin
                // The edge that first sees the synchronizer output high is stretch edge one.
                if (w_synced_release) begin
                    if (STRETCH_CYCLES == 1) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = {CW{1'b0}};
                    end else begin
                        w_state_nxt = ST_STRETCH;
                        w_cnt_nxt   = CW'(1);
                    end
                end else begin
                    w_cnt_nxt = {CW{1'b0}};
                end
            end
            ST_STRETCH: begin
                if (r_cnt == CW'(STRETCH_CYCLES - 1)) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_RUN: begin
                w_cnt_nxt = {CW{1'b0}};
                if (sw_reset_req) begin
                    w_state_nxt = ST_SW_PULSE;
                    if (r_count != {CNT_W{1'b1}}) begin
                        w_count_nxt = r_count + CNT_W'(1);
                    end else begin
                        w_count_nxt = r_count;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_SW_PULSE: begin
                if (r_cnt == CW'(PULSE_CYCLES - 1)) begin
                    w_state_nxt = ST_RUN;
                    w_cnt_nxt   = {CW{1'b0}};
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_HOLD;
                w_cnt_nxt   = {CW{1'b0}};
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    always_comb begin
        w_rst_out_nxt    = 1'b1;
        w_sync_reset_nxt = 1'b1;
        w_ready_nxt      = 1'b0;
        case (w_state_nxt)
            ST_HOLD, ST_STRETCH: begin
                w_rst_out_nxt    = 1'b1;
                w_sync_reset_nxt = 1'b1;
                w_ready_nxt      = 1'b0;
            end
            ST_RUN: begin
                w_rst_out_nxt    = 1'b0;
                w_sync_reset_nxt = 1'b0;
                w_ready_nxt      = 1'b1;
            end
            ST_SW_PULSE: begin
                w_rst_out_nxt    = 1'b0;
                w_sync_reset_nxt = 1'b1;
                w_ready_nxt      = 1'b0;
            end
            default: begin
                w_rst_out_nxt    = 1'b1;
                w_sync_reset_nxt = 1'b1;
                w_ready_nxt      = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs; raw reset forces the full reset image.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_state      <= ST_HOLD;
            r_cnt        <= {CW{1'b0}};
            r_count      <= {CNT_W{1'b0}};
            r_rst_out    <= 1'b1;
            r_sync_reset <= 1'b1;
            r_ready      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_count      <= w_count_nxt;
            r_rst_out    <= w_rst_out_nxt;
            r_sync_reset <= w_sync_reset_nxt;
            r_ready      <= w_ready_nxt;
        end
    end

    assign rst_out        = r_rst_out;
    assign sync_reset     = r_sync_reset;
    assign ready          = r_ready;
    assign sw_reset_count = r_count;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: expected output images are queued as
// stimulus is driven and popped when the DUT outputs are sampled.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       async_reset;
    logic       sw_reset_req;
    logic       rst_out;
    logic       sync_reset;
    logic       ready;
    logic [7:0] sw_reset_count;
    logic       rst_out_w2;
    logic       sync_reset_w2;
    logic       ready_w2;
    logic [1:0] sw_reset_count_w2;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       rst;
        logic       sync;
        logic       rdy;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb_q[$];

    always #10 clk = ~clk;

    reset_sequencer dut (
        .clk            (clk),
        .async_reset    (async_reset),
        .sw_reset_req   (sw_reset_req),
        .rst_out        (rst_out),
        .sync_reset     (sync_reset),
        .ready          (ready),
        .sw_reset_count (sw_reset_count)
    );

    reset_sequencer #(.CNT_W(2)) dut_w2 (
        .clk            (clk),
        .async_reset    (async_reset),
        .sw_reset_req   (sw_reset_req),
        .rst_out        (rst_out_w2),
        .sync_reset     (sync_reset_w2),
        .ready          (ready_w2),
        .sw_reset_count (sw_reset_count_w2)
    );

    task automatic expect_push(input logic r, input logic s, input logic y, input int c);
        exp_t e;
        e.rst  = r;
        e.sync = s;
        e.rdy  = y;
        e.cnt  = 8'(c);
        sb_q.push_back(e);
    endtask

    task automatic check_pop(input string tag);
        exp_t       e;
        exp_t       obs;
        logic [4:0] obs_w2;
        logic [4:0] exp_w2;
        checks++;
        if (sb_q.size() == 0) begin
            failures++;
            $error("FAIL %s: scoreboard empty, observed=%h expected=none", tag,
                   {rst_out, sync_reset, ready, sw_reset_count});
        end else begin
            e   = sb_q.pop_front();
            obs = {rst_out, sync_reset, ready, sw_reset_count};
            assert (obs === e) else begin
                failures++;
                $error("FAIL %s: observed rst/sync/rdy/cnt=%b/%b/%b/%0d expected=%b/%b/%b/%0d",
                       tag, obs.rst, obs.sync, obs.rdy, obs.cnt, e.rst, e.sync, e.rdy, e.cnt);
            end
            exp_w2 = {e.rst, e.sync, e.rdy, (e.cnt > 8'd3) ? 2'd3 : e.cnt[1:0]};
            obs_w2 = {rst_out_w2, sync_reset_w2, ready_w2, sw_reset_count_w2};
            checks++;
            assert (obs_w2 === exp_w2) else begin
                failures++;
                $error("FAIL %s_w2: observed=%b expected=%b", tag, obs_w2, exp_w2);
            end
        end
    endtask

    task automatic step(input logic req, input logic r, input logic s, input logic y,
                        input int c, input string tag);
        sw_reset_req = req;
        expect_push(r, s, y, c);
        @(posedge clk);
        #1;
        check_pop(tag);
    endtask

    // Edges 1..9 after release hold reset; edge 10 enters RUN. req_edge injects a request.
    task automatic release_seq(input int req_edge, input string tag);
        for (int e = 1; e <= 10; e++) begin
            if (e < 10) begin
                step((e == req_edge), 1'b1, 1'b1, 1'b0, 0, tag);
            end else begin
                step(1'b0, 1'b0, 1'b0, 1'b1, 0, tag);
            end
        end
    endtask

    // 3ns async_reset pulse between edges; reset image must appear with no clock edge.
    task automatic glitch_reset(input string tag);
        sw_reset_req = 1'b0;
        #5 async_reset = 1'b1;
        expect_push(1'b1, 1'b1, 1'b0, 0);
        #1;
        check_pop(tag);
        #2 async_reset = 1'b0;
    endtask

    initial begin
        async_reset  = 1'b1;
        sw_reset_req = 1'b0;

        // Test 1: power-on reset, release at 105ns.
        #50;
        expect_push(1'b1, 1'b1, 1'b0, 0);
        check_pop("t1_reset_state");
        #55 async_reset = 1'b0;
        release_seq(0, "t1_release");

        // Test 2: single-cycle request.
        step(1'b1, 1'b0, 1'b1, 1'b0, 1, "t2_pulse_start");
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, 1, "t2_pulse_body");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1, "t2_pulse_end");
        step(1'b0, 1'b0, 1'b0, 1'b1, 1, "t2_idle");

        // Test 3: request held for 20 cycles from a fresh reset.
        glitch_reset("t3_reset");
        release_seq(0, "t3_release");
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, (k % 5 != 4), (k % 5 == 4), k / 5 + 1, "t3_held");
        end
        step(1'b0, 1'b0, 1'b0, 1'b1, 4, "t3_end");

        // Test 4: glitch during cycle 2 of a software pulse.
        step(1'b1, 1'b0, 1'b1, 1'b0, 5, "t4_pulse_c1");
        step(1'b0, 1'b0, 1'b1, 1'b0, 5, "t4_pulse_c2");
        glitch_reset("t4_glitch");
        release_seq(0, "t4_release");

        // Test 5: request during STRETCH is ignored.
        glitch_reset("t5_reset");
        release_seq(5, "t5_stretch_req");
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b1, 0, "t5_no_pulse");

        // Test 6: five separate requests; the CNT_W=2 instance saturates at 3.
        for (int n = 1; n <= 5; n++) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, n, "t6_pulse_start");
            repeat (3) step(1'b0, 1'b0, 1'b1, 1'b0, n, "t6_pulse_body");
            step(1'b0, 1'b0, 1'b0, 1'b1, n, "t6_run");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
